// File: rtl/aes_display_sequencer.sv
// Steps through the 16 bytes of a captured 128-bit AES block for a 2-digit hex display,
// advancing on a dwell timer (auto mode) or on a button rising edge.
module aes_display_sequencer #(
  parameter int unsigned DWELL = 50000000,
  parameter int unsigned CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] data_in,
  input  logic         data_valid,
  input  logic         next_btn,
  input  logic         auto_en,
  output logic [7:0]   byte_out,
  output logic [3:0]   byte_idx,
  output logic         busy,
  output logic         wrap
);

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           state, state_n;
  logic [127:0]     shadow, shadow_n;
  logic [CNT_W-1:0] dwell_cnt, dwell_cnt_n;
  logic             btn_q;
  logic [3:0]       idx_n;
  logic [7:0]       byte_n;
  logic             busy_n, wrap_n;
  logic             btn_rise, expire, advance;
  logic [6:0]       byte_lsb;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the reset branch also clears the 128-bit shadow because a
  // reset must discard any block that was being displayed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shadow    <= '0;
      dwell_cnt <= '0;
      btn_q     <= 1'b0;
      byte_idx  <= '0;
      byte_out  <= '0;
      busy      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_n;
      shadow    <= shadow_n;
      dwell_cnt <= dwell_cnt_n;
      btn_q     <= next_btn;
      byte_idx  <= idx_n;
      byte_out  <= byte_n;
      busy      <= busy_n;
      wrap      <= wrap_n;
    end
  end

  assign btn_rise = next_btn & ~btn_q;
  assign expire   = auto_en && (dwell_cnt == CNT_LAST);
  assign advance  = btn_rise | expire;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_n     = state;
    shadow_n    = shadow;
    dwell_cnt_n = dwell_cnt;
    idx_n       = byte_idx;
    wrap_n      = 1'b0;
    busy_n      = busy;

    unique case (state)
      IDLE: begin
        idx_n       = '0;
        dwell_cnt_n = '0;
        busy_n      = 1'b0;
        if (data_valid) begin
          state_n  = SHOW;
          shadow_n = data_in;
          busy_n   = 1'b1;
        end
      end
      SHOW: begin
        busy_n = 1'b1;
        if (data_valid) begin
          // A reload wins over any advance arriving in the same cycle.
          shadow_n    = data_in;
          idx_n       = '0;
          dwell_cnt_n = '0;
        end else begin
          if (advance) begin
            idx_n  = byte_idx + 4'd1;
            wrap_n = (byte_idx == 4'd15);
          end
          if (btn_rise || !auto_en || expire) dwell_cnt_n = '0;
          else                                dwell_cnt_n = dwell_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Index 0 is the MSB byte: bit offset of byte i is 8*(15-i), and 15-i == ~i on 4 bits.
  assign byte_lsb = {~idx_n, 3'b000};

  always_comb begin
    byte_n = '0;
    if (state_n == SHOW) byte_n = shadow_n[byte_lsb +: 8];
  end

endmodule
